// File: rtl/elevator_pkg.sv
// Shared types and sizes for the 4-level elevator car controller.
package elevator_pkg;
  localparam int NUM_LVL = 4;
  localparam int LVL_W   = 2;
  localparam int Q_DEPTH = NUM_LVL;
  localparam int TAIL_W  = 3;
  localparam int Q_W     = LVL_W * Q_DEPTH;

  localparam logic [TAIL_W-1:0] Q_FULL = TAIL_W'(Q_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_e;

  function automatic logic [LVL_W-1:0] get_entry(input logic [Q_W-1:0] q, input int i);
    return q[i*LVL_W +: LVL_W];
  endfunction
endpackage

// File: rtl/add_new_lvl_logic.sv
// Admission check: a press is accepted only if its level is not already among the valid entries.
module add_new_lvl_logic
  import elevator_pkg::*;
(
  input  logic              pressed_en_i,
  input  logic [LVL_W-1:0]  pressed_lvl_i,
  input  logic [Q_W-1:0]    queue_i,
  input  logic [TAIL_W-1:0] tail_i,
  output logic              add_new_lvl_o
);
  logic dup;

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      if ((TAIL_W'(i) < tail_i) && (get_entry(queue_i, i) == pressed_lvl_i)) dup = 1'b1;
    end
    add_new_lvl_o = pressed_en_i & ~dup;
  end
endmodule

// File: rtl/elevator_queue_ctrl.sv
// Car controller: FIFO of requested levels, served in order with one-level-per-MOVE_CYCLES travel.
module elevator_queue_ctrl
  import elevator_pkg::*;
#(
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pressed_en,
  input  logic [LVL_W-1:0]  pressed_lvl,
  output logic [LVL_W-1:0]  cur_lvl,
  output logic              moving_up,
  output logic              moving_down,
  output logic              door_open,
  output logic              arrived,
  output logic [Q_W-1:0]    queue,
  output logic [TAIL_W-1:0] tail,
  output state_e            fsm_state
);
  localparam int CNT_W = $clog2(MOVE_CYCLES > DOOR_CYCLES ? MOVE_CYCLES : DOOR_CYCLES);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);

  state_e            state_q, state_d;
  logic [LVL_W-1:0]  cur_lvl_q, cur_lvl_d;
  logic [Q_W-1:0]    queue_q, queue_d;
  logic [TAIL_W-1:0] tail_q, tail_d, slot;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              arrived_q, arrived_d;
  logic              deq, enq, add_new_lvl, door_reload;
  logic [LVL_W-1:0]  head;

  assign head = get_entry(queue_q, 0);

  add_new_lvl_logic u_add_new_lvl (
    .pressed_en_i  (pressed_en),
    .pressed_lvl_i (pressed_lvl),
    .queue_i       (queue_q),
    .tail_i        (tail_q),
    .add_new_lvl_o (add_new_lvl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_lvl_q <= '0;
      queue_q   <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      arrived_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_lvl_q <= cur_lvl_d;
      queue_q   <= queue_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      arrived_q <= arrived_d;
    end
  end

  // A press of the current level while the door is open keeps it open instead of queueing.
  always_comb begin
    state_d     = state_q;
    cur_lvl_d   = cur_lvl_q;
    cnt_d       = cnt_q;
    deq         = 1'b0;
    arrived_d   = 1'b0;
    door_reload = pressed_en && (state_q == DOOR) && (pressed_lvl == cur_lvl_q);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tail_q != '0) begin
          if (head == cur_lvl_q) begin
            state_d   = DOOR;
            deq       = 1'b1;
            arrived_d = 1'b1;
          end else if (head > cur_lvl_q) begin
            state_d = MOVE_UP;
          end else begin
            state_d = MOVE_DOWN;
          end
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (cnt_q == MOVE_LAST) begin
          cnt_d     = '0;
          cur_lvl_d = (state_q == MOVE_UP) ? cur_lvl_q + LVL_W'(1) : cur_lvl_q - LVL_W'(1);
          if (cur_lvl_d == head) begin
            state_d   = DOOR;
            deq       = 1'b1;
            arrived_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOOR: begin
        if (door_reload) begin
          cnt_d = '0;
        end else if (cnt_q == DOOR_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift happens before append, so a same-edge append lands at the post-shift tail.
  always_comb begin
    enq     = add_new_lvl && (tail_q < Q_FULL) && !door_reload;
    queue_d = queue_q;
    tail_d  = tail_q;
    slot    = deq ? tail_q - TAIL_W'(1) : tail_q;
    if (deq) begin
      queue_d = {LVL_W'(0), queue_q[Q_W-1:LVL_W]};
      tail_d  = tail_d - TAIL_W'(1);
    end
    if (enq) begin
      for (int i = 0; i < Q_DEPTH; i++) begin
        if (slot == TAIL_W'(i)) queue_d[i*LVL_W +: LVL_W] = pressed_lvl;
      end
      tail_d = tail_d + TAIL_W'(1);
    end
  end

  always_comb begin
    moving_up   = (state_q == MOVE_UP);
    moving_down = (state_q == MOVE_DOWN);
    door_open   = (state_q == DOOR);
    arrived     = arrived_q;
    cur_lvl     = cur_lvl_q;
    queue       = queue_q;
    tail        = tail_q;
    fsm_state   = state_q;
  end
endmodule

// File: tb/tb_elevator_queue_ctrl.sv
// Directed bench for elevator_queue_ctrl with an arrival scoreboard and a motor/door exclusivity monitor.
module tb_elevator_queue_ctrl;
  import elevator_pkg::*;

  logic       clk;
  logic       rst;
  logic       pressed_en;
  logic [1:0] pressed_lvl;
  logic [1:0] cur_lvl;
  logic       moving_up, moving_down, door_open, arrived;
  logic [7:0] queue;
  logic [2:0] tail;
  state_e     fsm_state;

  int n_chk = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  elevator_queue_ctrl #(.MOVE_CYCLES(8), .DOOR_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pressed_en  (pressed_en),
    .pressed_lvl (pressed_lvl),
    .cur_lvl     (cur_lvl),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .door_open   (door_open),
    .arrived     (arrived),
    .queue       (queue),
    .tail        (tail),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] lvl);
    pressed_en  = 1'b1;
    pressed_lvl = lvl;
    tick();
    pressed_en  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(fsm_state == IDLE && tail == 3'd0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(fsm_state == IDLE && tail == 3'd0), 1);
  endtask

  // scoreboard: arrivals in expected order, and at most one of motor/door active
  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot", int'((int'(moving_up) + int'(moving_down) + int'(door_open)) > 1), 0);
      if (arrived) begin
        if (exp_q.size() == 0) chk("arrive_extra", exp_q.size(), 1);
        else chk("arrive_lvl", cur_lvl, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    pressed_en = 1'b0;
    pressed_lvl = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_cur", cur_lvl, 0);
    chk("por_outs", {moving_up, moving_down, door_open, arrived}, 0);
    chk("por_queue", queue, 0);
    chk("por_tail", tail, 0);
    #2 rst = 1'b0;

    // async reset mid-travel
    press(2'd2);
    press(2'd3);
    chk("t1_tail", tail, 2);
    chk("t1_up", moving_up, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t1_queue", queue, 0);
    chk("t1_tail0", tail, 0);
    chk("t1_cur", cur_lvl, 0);
    chk("t1_up0", moving_up, 0);
    #1 rst = 1'b0;
    tick();

    // single request 0 -> 2
    exp_q.push_back(2'd2);
    press(2'd2);
    chk("t2_tail", tail, 1);
    chk("t2_queue", queue, 8'h02);
    chk("t2_not_yet", moving_up, 0);
    tick();
    chk("t2_up_e1", moving_up, 1);
    repeat (7) tick();
    chk("t2_cur_e8", cur_lvl, 0);
    tick();
    chk("t2_cur_e9", cur_lvl, 1);
    repeat (7) tick();
    chk("t2_up_e16", moving_up, 1);
    tick();
    chk("t2_cur_e17", cur_lvl, 2);
    chk("t2_door_e17", door_open, 1);
    chk("t2_arr_e17", arrived, 1);
    chk("t2_tail_e17", tail, 0);
    tick();
    chk("t2_arr_e18", arrived, 0);
    tick();
    tick();
    chk("t2_door_e20", door_open, 1);
    tick();
    chk("t2_door_e21", door_open, 0);
    chk("t2_idle_e21", int'(fsm_state), int'(IDLE));

    // duplicates dropped, then 3 then 1
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    press(2'd3);
    press(2'd3);
    chk("t3_dup_tail", tail, 1);
    press(2'd1);
    chk("t3_queue", queue, 8'h07);
    chk("t3_tail", tail, 2);
    repeat (6) tick();
    chk("t3_cur_a8", cur_lvl, 2);
    tick();
    chk("t3_cur_a9", cur_lvl, 3);
    chk("t3_door_a9", door_open, 1);
    chk("t3_queue_a9", queue, 8'h01);
    repeat (5) tick();
    chk("t3_down_a14", moving_down, 1);
    repeat (16) tick();
    chk("t3_cur_a30", cur_lvl, 1);
    chk("t3_door_a30", door_open, 1);
    chk("t3_tail_a30", tail, 0);
    wait_idle("t3_idle", 50);

    // go to level 0, then press the current level while idle and while the door is open
    exp_q.push_back(2'd0);
    press(2'd0);
    wait_idle("t4_home", 50);
    chk("t4_cur0", cur_lvl, 0);
    exp_q.push_back(2'd0);
    press(2'd0);
    chk("t4_tail1", tail, 1);
    chk("t4_door_c0", door_open, 0);
    tick();
    chk("t4_door_c1", door_open, 1);
    chk("t4_tail_c1", tail, 0);
    tick();
    press(2'd0);
    chk("t4_reload_tail", tail, 0);
    tick();
    tick();
    chk("t4_door_c5", door_open, 1);
    tick();
    chk("t4_door_c6", door_open, 1);
    tick();
    chk("t4_door_c7", door_open, 0);

    // append on the same edge as a dequeue
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    press(2'd2);
    press(2'd3);
    chk("t5_queue_pre", queue, 8'h0E);
    repeat (15) tick();
    chk("t5_cur_d16", cur_lvl, 1);
    press(2'd1);
    chk("t5_cur_d17", cur_lvl, 2);
    chk("t5_queue", queue, 8'h07);
    chk("t5_tail", tail, 2);
    wait_idle("t5_idle", 150);

    // press of the level being dequeued on that edge is dropped
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    press(2'd2);
    press(2'd3);
    repeat (7) tick();
    press(2'd2);
    chk("t5b_door", door_open, 1);
    chk("t5b_queue", queue, 8'h03);
    chk("t5b_tail", tail, 1);
    wait_idle("t5b_idle", 100);

    // fill the queue
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    press(2'd0);
    press(2'd1);
    press(2'd2);
    press(2'd3);
    chk("t6_tail_full", tail, 4);
    chk("t6_queue", queue, 8'hE4);
    press(2'd1);
    press(2'd3);
    chk("t6_tail_hold", tail, 4);
    chk("t6_queue_hold", queue, 8'hE4);
    chk("t6_down", moving_down, 1);
    wait_idle("t6_idle", 300);
    chk("t6_cur", cur_lvl, 3);

    tick();
    chk("exp_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
